// File: rtl/tweak_exec_unit.sv
// tweak_exec_unit: execute stage of the tweakpu core.
//   A register file, an ALU and write-back sit behind a valid/ready instruction port.
//   An accepted word is captured into D. E works on D in the following cycle and writes
//   the register file at the end of that cycle. wb_valid/wb_addr/wb_data are the
//   registered image of that write.
//   With SERIAL_SHIFT=1, shifts by a nonzero amount move one bit per cycle in SHIFT.
// Ports:
//   CLK, RESET           clock; synchronous active-high reset
//   ins_valid/ins_ready  instruction handshake; ins_word is the 32-bit instruction
//   wb_valid/addr/data   one-cycle retire pulse with the written register and value
//   flag_z, flag_c       zero flag / carry-borrow flag of the last flag-setting ALU op
//   busy                 an instruction is held in D/E
//   dbg_addr, dbg_data   combinational register read (0 for unimplemented indices)
module tweak_exec_unit #(
  parameter int WIDTH        = 32,
  parameter int NUMREGS      = 16,
  parameter int SERIAL_SHIFT = 0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ins_valid,
  output logic             ins_ready,
  input  logic [31:0]      ins_word,
  output logic             wb_valid,
  output logic [3:0]       wb_addr,
  output logic [WIDTH-1:0] wb_data,
  output logic             flag_z,
  output logic             flag_c,
  output logic             busy,
  input  logic [3:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);
  localparam int CW = 7;  // holds a clamped shift count up to 64

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_SHIFT} state_e;

  state_e                         state_q, state_d;
  logic [31:0]                    d_q, d_d;
  logic [NUMREGS-1:0][WIDTH-1:0]  regs_q;
  logic [WIDTH-1:0]               sh_q, sh_d, sh_nxt;
  logic [CW-1:0]                  cnt_q, cnt_d;
  logic                           wb_valid_q, flag_z_q, flag_c_q;
  logic [3:0]                     wb_addr_q;
  logic [WIDTH-1:0]               wb_data_q;

  logic [3:0]       enc, op, ra, rb, rd;
  logic [WIDTH-1:0] a, b, imm_w;
  logic [WIDTH:0]   sum, diff;
  logic             amt_big, is_shift, start_shift;
  logic [CW-1:0]    amt7;
  logic             ex_we, ex_fl, ex_c;
  logic [3:0]       ex_addr;
  logic [WIDTH-1:0] ex_data;
  logic             wr_en, fl_upd, c_d;
  logic [3:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;

  assign enc = d_q[31:28];
  assign op  = d_q[27:24];
  assign ra  = d_q[23:20];
  assign rb  = d_q[19:16];
  assign rd  = d_q[15:12];

  // Immediate is zero-extended or truncated to WIDTH.
  if (WIDTH > 24) begin : g_imm_ext
    assign imm_w = {{(WIDTH-24){1'b0}}, d_q[23:0]};
  end else if (WIDTH == 24) begin : g_imm_eq
    assign imm_w = d_q[23:0];
  end else begin : g_imm_trunc
    assign imm_w = d_q[WIDTH-1:0];
  end

  // Register reads; unimplemented indices read as 0.
  always_comb begin
    a        = '0;
    b        = '0;
    dbg_data = '0;
    for (int i = 0; i < NUMREGS; i++) begin
      if (ra == 4'(i))       a        = regs_q[i];
      if (rb == 4'(i))       b        = regs_q[i];
      if (dbg_addr == 4'(i)) dbg_data = regs_q[i];
    end
  end

  // Shift amount clamped to WIDTH; amt_big marks amounts that shift everything out.
  assign amt_big = (b[WIDTH-1:CW] != '0) || (b[CW-1:0] >= CW'(WIDTH));
  assign amt7    = amt_big ? CW'(WIDTH) : b[CW-1:0];

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};  // MSB is the borrow

  assign is_shift    = (enc == 4'd1) && (op == 4'd6 || op == 4'd7 || op == 4'd8);
  assign start_shift = (SERIAL_SHIFT != 0) && (state_q == S_EXEC) && is_shift && (amt7 != '0);

  always_comb begin
    ex_we   = 1'b0;
    ex_fl   = 1'b0;
    ex_c    = 1'b0;
    ex_addr = rd;
    ex_data = a;
    case (enc)
      4'd0: begin
        ex_we   = 1'b1;
        ex_addr = d_q[27:24];
        ex_data = imm_w;
      end
      4'd1: begin
        ex_we = (op != 4'd0);
        ex_fl = (op != 4'd0);
        case (op)
          4'd1:    {ex_c, ex_data} = sum;
          4'd2:    {ex_c, ex_data} = diff;
          4'd3:    ex_data = a & b;
          4'd4:    ex_data = a | b;
          4'd5:    ex_data = a ^ b;
          4'd6:    ex_data = amt_big ? '0 : a << amt7;
          4'd7:    ex_data = amt_big ? {WIDTH{a[WIDTH-1]}} : WIDTH'($signed(a) >>> amt7);
          4'd8:    ex_data = amt_big ? '0 : a >> amt7;
          default: ex_data = a;
        endcase
      end
      default: ;
    endcase
  end

  // One-bit step of the serial shifter, direction from the held opcode.
  always_comb begin
    case (op)
      4'd6:    sh_nxt = {sh_q[WIDTH-2:0], 1'b0};
      4'd7:    sh_nxt = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
      default: sh_nxt = {1'b0, sh_q[WIDTH-1:1]};
    endcase
  end

  always_comb begin
    state_d   = state_q;
    d_d       = d_q;
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    ins_ready = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = ex_addr;
    wr_data   = ex_data;
    fl_upd    = 1'b0;
    c_d       = ex_c;
    case (state_q)
      S_IDLE: ins_ready = 1'b1;
      S_EXEC: begin
        if (start_shift) begin
          state_d = S_SHIFT;
          sh_d    = a;
          cnt_d   = amt7;
        end else begin
          ins_ready = 1'b1;
          wr_en     = ex_we;
          fl_upd    = ex_fl;
        end
      end
      S_SHIFT: begin
        sh_d  = sh_nxt;
        cnt_d = cnt_q - CW'(1);
        // Last bit step: retire now so the next instruction can enter behind it.
        if (cnt_q == CW'(1)) begin
          ins_ready = 1'b1;
          wr_en     = 1'b1;
          wr_addr   = rd;
          wr_data   = sh_nxt;
          fl_upd    = 1'b1;
          c_d       = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (ins_ready) begin
      state_d = ins_valid ? S_EXEC : S_IDLE;
      if (ins_valid) d_d = ins_word;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      d_q        <= '0;
      sh_q       <= '0;
      cnt_q      <= '0;
      regs_q     <= '0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      flag_z_q   <= 1'b0;
      flag_c_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      d_q        <= d_d;
      sh_q       <= sh_d;
      cnt_q      <= cnt_d;
      wb_valid_q <= wr_en;
      if (wr_en) begin
        wb_addr_q <= wr_addr;
        wb_data_q <= wr_data;
        for (int i = 0; i < NUMREGS; i++)
          if (wr_addr == 4'(i)) regs_q[i] <= wr_data;
      end
      if (fl_upd) begin
        flag_z_q <= (wr_data == '0);
        flag_c_q <= c_d;
      end
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_addr  = wb_addr_q;
  assign wb_data  = wb_data_q;
  assign flag_z   = flag_z_q;
  assign flag_c   = flag_c_q;
  assign busy     = (state_q != S_IDLE);
endmodule

// File: tb/tb_tweak_exec_unit.sv
// Directed bench: u0 = 32-bit/16 regs/barrel shifter, u1 = 24-bit/8 regs/serial shifter.
module tb_tweak_exec_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, v0, rdy0, wbv0, fz0, fc0, busy0;
  logic [31:0] w0, wbd0, dbd0;
  logic [3:0]  wba0, dba0;
  logic        rst1, v1, rdy1, wbv1, fz1, fc1, busy1;
  logic [31:0] w1;
  logic [23:0] wbd1, dbd1;
  logic [3:0]  wba1, dba1;

  tweak_exec_unit #(.WIDTH(32), .NUMREGS(16), .SERIAL_SHIFT(0)) u0 (
    .CLK(clk), .RESET(rst0), .ins_valid(v0), .ins_ready(rdy0), .ins_word(w0),
    .wb_valid(wbv0), .wb_addr(wba0), .wb_data(wbd0), .flag_z(fz0), .flag_c(fc0),
    .busy(busy0), .dbg_addr(dba0), .dbg_data(dbd0));

  tweak_exec_unit #(.WIDTH(24), .NUMREGS(8), .SERIAL_SHIFT(1)) u1 (
    .CLK(clk), .RESET(rst1), .ins_valid(v1), .ins_ready(rdy1), .ins_word(w1),
    .wb_valid(wbv1), .wb_addr(wba1), .wb_data(wbd1), .flag_z(fz1), .flag_c(fc1),
    .busy(busy1), .dbg_addr(dba1), .dbg_data(dbd1));

  int checks = 0, errors = 0;
  int cyc = 0, rl0 = 0, rl1 = 0;
  logic [3:0]  q0a[$], q1a[$];
  logic [63:0] q0d[$], q1d[$];
  int          q0c[$], q1c[$];

  // Write-back log and ready-low cycle counts.
  always @(negedge clk) begin
    cyc++;
    if (wbv0) begin q0a.push_back(wba0); q0d.push_back(64'(wbd0)); q0c.push_back(cyc); end
    if (wbv1) begin q1a.push_back(wba1); q1d.push_back(64'(wbd1)); q1c.push_back(cyc); end
    if (!rdy0) rl0++;
    if (!rdy1) rl1++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ldi(input logic [3:0] d, input logic [23:0] imm);
    return {4'h0, d, imm};
  endfunction

  function automatic logic [31:0] alu(input logic [3:0] op, ra, rb, rd);
    return {4'h1, op, ra, rb, rd, 12'h000};
  endfunction

  // Present a word at a falling edge and hold it until the rising edge that takes it.
  task automatic issue(input int u, input logic [31:0] w);
    int n = 0;
    if (u == 0) begin v0 = 1'b1; w0 = w; end else begin v1 = 1'b1; w1 = w; end
    while (((u == 0) ? !rdy0 : !rdy1) && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("issue_timeout", 64'(n), 64'd0);
    @(negedge clk);
    v0 = 1'b0;
    v1 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic dchk(input int u, input string tag, input logic [3:0] idx, input logic [63:0] exp);
    if (u == 0) dba0 = idx; else dba1 = idx;
    #1;
    chk(tag, (u == 0) ? 64'(dbd0) : 64'(dbd1), exp);
  endtask

  int n_wb, n_rl;

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; v0 = 1'b0; v1 = 1'b0;
    w0 = '0; w1 = '0; dba0 = '0; dba1 = '0;
    idle(3);
    chk("rst_ready0", rdy0, 1); chk("rst_wbv0", wbv0, 0); chk("rst_busy0", busy0, 0);
    chk("rst_flags0", {fz0, fc0}, 0); chk("rst_wb0", {wba0, wbd0}, 0);
    chk("rst_ready1", rdy1, 1); chk("rst_wbv1", wbv1, 0); chk("rst_busy1", busy1, 0);
    dchk(0, "rst_r0", 4'd0, 0);
    rst0 = 1'b0; rst1 = 1'b0;
    idle(1);

    // Plain add through the pipe, 1 instruction per cycle.
    issue(0, ldi(4'd0, 24'h888888));
    issue(0, ldi(4'd1, 24'h444444));
    issue(0, alu(4'd1, 4'd0, 4'd1, 4'd2));
    idle(3);
    chk("t1_nwb", q0d.size(), 3);
    chk("t1_wb2", {q0a[2], q0d[2]}, {4'd2, 64'hCCCCCC});
    chk("t1_wb0", {q0a[0], q0d[0]}, {4'd0, 64'h888888});
    chk("t1_thru", 64'(q0c[2] - q0c[0]), 2);
    chk("t1_flags", {fz0, fc0}, 2'b00);
    dchk(0, "t1_r2", 4'd2, 64'hCCCCCC);

    // Barrel shifts, including out-of-range amounts.
    issue(0, ldi(4'd1, 24'd1));
    issue(0, ldi(4'd0, 24'd31));
    issue(0, alu(4'd6, 4'd1, 4'd0, 4'd1));
    issue(0, ldi(4'd0, 24'd4));
    issue(0, alu(4'd7, 4'd1, 4'd0, 4'd2));
    issue(0, alu(4'd8, 4'd1, 4'd0, 4'd3));
    issue(0, ldi(4'd0, 24'd40));
    issue(0, alu(4'd6, 4'd1, 4'd0, 4'd4));
    idle(3);
    chk("t3_z_asl40", fz0, 1);
    dchk(0, "t3_r1", 4'd1, 64'h80000000);
    dchk(0, "t3_asr4", 4'd2, 64'hF8000000);
    dchk(0, "t3_lsr4", 4'd3, 64'h08000000);
    dchk(0, "t3_asl40", 4'd4, 64'h0);

    issue(0, alu(4'd7, 4'd1, 4'd0, 4'd5));
    issue(0, ldi(4'd6, 24'd1));
    issue(0, alu(4'd2, 4'd6, 4'd0, 4'd7));
    issue(0, ldi(4'd11, 24'd7));
    idle(3);
    chk("sub_borrow", {fz0, fc0}, 2'b01);
    dchk(0, "asr40", 4'd5, 64'hFFFFFFFF);
    dchk(0, "sub_res", 4'd7, 64'hFFFFFFD9);

    n_wb = q0d.size();
    issue(0, alu(4'd3, 4'd6, 4'd6, 4'd8));
    issue(0, alu(4'd9, 4'd7, 4'd0, 4'd9));
    issue(0, alu(4'd0, 4'd6, 4'd6, 4'd10));
    issue(0, 32'h3123_4000);
    idle(3);
    chk("nop_wbcount", 64'(q0d.size() - n_wb), 2);
    chk("and_clr_c", {fz0, fc0}, 2'b00);
    dchk(0, "and_res", 4'd8, 64'h1);
    dchk(0, "pass_res", 4'd9, 64'hFFFFFFD9);
    dchk(0, "nop_nowrite", 4'd10, 64'h0);
    chk("u0_never_stalls", 64'(rl0), 0);

    // 24-bit add with carry-out and zero result, back to back.
    n_rl = rl1;
    issue(1, ldi(4'd0, 24'd1));
    issue(1, ldi(4'd1, 24'hFFFFFF));
    issue(1, alu(4'd1, 4'd0, 4'd1, 4'd3));
    idle(3);
    chk("t2_flags", {fz1, fc1}, 2'b11);
    dchk(1, "t2_r3", 4'd3, 64'h0);
    chk("t2_nostall", 64'(rl1 - n_rl), 0);

    // Serial shift by 5 with an add queued behind it.
    n_rl = rl1;
    issue(1, ldi(4'd4, 24'd5));
    issue(1, ldi(4'd5, 24'd3));
    issue(1, alu(4'd6, 4'd5, 4'd4, 4'd6));
    issue(1, alu(4'd1, 4'd5, 4'd5, 4'd7));
    idle(8);
    chk("t4_ready_low", 64'(rl1 - n_rl), 5);
    chk("t4_shift_wb", {q1a[q1a.size()-2], q1d[q1d.size()-2]}, {4'd6, 64'h60});
    chk("t4_add_wb", {q1a[q1a.size()-1], q1d[q1d.size()-1]}, {4'd7, 64'h6});
    chk("t4_add_next", 64'(q1c[q1c.size()-1] - q1c[q1c.size()-2]), 1);
    dchk(1, "t4_r6", 4'd6, 64'h60);

    issue(1, ldi(4'd1, 24'h800000));
    issue(1, alu(4'd7, 4'd1, 4'd4, 4'd2));
    issue(1, alu(4'd8, 4'd1, 4'd4, 4'd3));
    issue(1, ldi(4'd0, 24'd30));
    issue(1, alu(4'd7, 4'd1, 4'd0, 4'd5));
    idle(30);
    dchk(1, "ser_asr5", 4'd2, 64'hFC0000);
    dchk(1, "ser_lsr5", 4'd3, 64'h040000);
    dchk(1, "ser_asr30", 4'd5, 64'hFFFFFF);

    n_rl = rl1;
    issue(1, ldi(4'd0, 24'd0));
    issue(1, alu(4'd8, 4'd1, 4'd0, 4'd3));
    idle(3);
    chk("ser_amt0_nostall", 64'(rl1 - n_rl), 0);
    dchk(1, "ser_amt0", 4'd3, 64'h800000);

    // Unimplemented register index and unused encodings.
    issue(1, ldi(4'd12, 24'd5));
    idle(3);
    chk("hi_idx_wb", {q1a[q1a.size()-1], q1d[q1d.size()-1]}, {4'd12, 64'h5});
    dchk(1, "hi_idx_read", 4'd12, 64'h0);
    dchk(1, "hi_idx_alias", 4'd4, 64'h5);
    n_wb = q1d.size();
    issue(1, 32'h3000_0005);
    idle(3);
    chk("enc3_nowb", 64'(q1d.size() - n_wb), 0);

    // Reset in the middle of a long serial shift.
    issue(1, ldi(4'd4, 24'd20));
    issue(1, alu(4'd6, 4'd5, 4'd4, 4'd6));
    idle(4);
    chk("t5_busy", busy1, 1);
    n_wb = q1d.size();
    rst1 = 1'b1;
    idle(1);
    chk("t5_ready", rdy1, 1);
    chk("t5_idle", busy1, 0);
    chk("t5_wbout", {wbv1, wba1, wbd1}, 0);
    rst1 = 1'b0;
    idle(25);
    chk("t5_nowb", 64'(q1d.size() - n_wb), 0);
    for (int i = 0; i < 8; i++) dchk(1, "t5_reg", 4'(i), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
